// File: rtl/security_decrypt_pkg.sv
// Shared constants and types for the memory-path cipher (decrypt and encrypt sides).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package security_decrypt_pkg;

  localparam logic [15:0] KEY_VALUE = 16'h0032;
  localparam logic [31:0] INV3      = 32'hAAAAAAAB;
  localparam logic [31:0] SUB_OFS   = 32'd3;
  localparam logic [31:0] XOR_MASK  = 32'h2;
  localparam logic [31:0] ADD_OFS   = 32'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIN,
    ST_HOLD
  } state_t;

  // Undo the additive and xor stages once the multiply-by-3 has been removed.
  function automatic logic [31:0] fin_decode(input logic [31:0] c);
    return ((c - ADD_OFS) ^ XOR_MASK) + SUB_OFS;
  endfunction

endpackage

// File: rtl/security_decrypt_if.sv
// Valid/ready request and response bundle for the decrypt engine.
// Latency: n/a (wires only).
// Backpressure: in_ready stalls the producer, out_ready stalls the engine.
interface security_decrypt_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        decrypt_on;
  logic [15:0] key_access;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        key_err;
  logic        busy;

  modport master (
    output in_valid, data_in, decrypt_on, key_access, out_ready,
    input  in_ready, out_valid, data_out, key_err, busy
  );

  modport slave (
    input  in_valid, data_in, decrypt_on, key_access, out_ready,
    output in_ready, out_valid, data_out, key_err, busy
  );
endinterface

// File: rtl/security_decrypt_const_mul_iter.sv
// Iterative shift-add multiply of a 32-bit operand by a fixed constant, mod 2^32.
// Latency: 32/ITER_BITS steps; the start edge performs step 0, done is high during the last step.
// Backpressure: none; runs to completion once started, product holds until the next start.
module const_mul_iter
  import security_decrypt_pkg::*;
#(
  parameter logic [31:0] CONST     = INV3,
  parameter int          ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        done,
  output logic [31:0] product
);

  localparam int STEPS = 32 / ITER_BITS;

  logic [31:0] opnd;
  logic [31:0] acc;
  logic [5:0]  cnt;
  logic        run;

  // Sum of operand shifted by each set constant bit in chunk k.
  function automatic logic [31:0] chunk_sum(input logic [31:0] x, input logic [5:0] k);
    logic [31:0] s;
    logic [4:0]  b;
    s = '0;
    for (int j = 0; j < ITER_BITS; j++) begin
      b = 5'(int'(k) * ITER_BITS + j);
      if (CONST[b]) s = s + (x << b);
    end
    return s;
  endfunction

  assign done    = run && (cnt == 6'(STEPS - 1));
  assign product = acc;

  // Accumulate one chunk of constant bits per cycle; start folds in chunk 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      opnd <= operand;
      acc  <= chunk_sum(operand, 6'd0);
      cnt  <= 6'd1;
      run  <= 1'b1;
    end else if (run) begin
      acc <= acc + chunk_sum(opnd, cnt);
      cnt <= cnt + 6'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/security_decrypt.sv
// Read-path decrypt engine: inverts y = (((x-3)^2)+9)*3 mod 2^32, one word in flight.
// Latency: decrypt 32/ITER_BITS+1 cycles from accept, bypass/key error 1 cycle.
// Backpressure: in_ready low from accept until the result handshake; result held until out_ready.
module security_decrypt
  import security_decrypt_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
  input logic               clk,
  input logic               rst,
  security_decrypt_if.slave bus
);

  state_t      state;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] data_out_q;
  logic        key_err_q;
  logic        busy_q;

  logic        key_ok;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;

  assign key_ok    = (bus.key_access == KEY_VALUE);
  // The accept edge launches the multiplier directly from data_in, so it doubles as the first step.
  assign mul_start = (state == ST_IDLE) && bus.in_valid && key_ok && bus.decrypt_on;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.key_err   = key_err_q;
  assign bus.busy      = busy_q;

  const_mul_iter #(
    .CONST     (INV3),
    .ITER_BITS (ITER_BITS)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .operand (bus.data_in),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (!key_ok || !bus.decrypt_on) begin
              state       <= ST_HOLD;
              data_out_q  <= bus.data_in;
              key_err_q   <= !key_ok;
              out_valid_q <= 1'b1;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) state <= ST_FIN;
        end
        ST_FIN: begin
          data_out_q  <= fin_decode(mul_product);
          key_err_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_security_decrypt.sv
// Bench for security_decrypt: directed scenarios on ITER_BITS=1 plus an encrypt->decrypt sweep on 1/2/4.
// Latency: checked per scenario against 32/ITER_BITS+1 (decrypt) and 1 (bypass / key error).
// Backpressure: exercises out_ready stalls in HOLD and back-to-back accepts after the handshake.
module tb_security_decrypt;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        iv   [3];
  logic        dec  [3];
  logic        ordy [3];
  logic [31:0] din  [3];
  logic [15:0] key  [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        err  [3];
  logic        bsy  [3];
  logic [31:0] dout [3];

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    security_decrypt_if bus ();
    security_decrypt #(.ITER_BITS(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.in_valid   = iv[g];
    assign bus.data_in    = din[g];
    assign bus.decrypt_on = dec[g];
    assign bus.key_access = key[g];
    assign bus.out_ready  = ordy[g];
    assign ir[g]   = bus.in_ready;
    assign ov[g]   = bus.out_valid;
    assign err[g]  = bus.key_err;
    assign bsy[g]  = bus.busy;
    assign dout[g] = bus.data_out;
  end

  function automatic logic [31:0] enc(input logic [31:0] x);
    return (((x - 32'd3) ^ 32'd2) + 32'd9) * 32'd3;
  endfunction

  // Wait (bounded) for in_ready, present one word, push its expected result, return #1 after the accept edge.
  task automatic drive(input int d, input logic [31:0] data, input logic dc, input logic [15:0] k,
                       input logic [31:0] exp_dat, input logic exp_err);
    int n = 0;
    while (!ir[d] && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (ir[d] !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait dut=%0d in_ready=%b expected=1", d, ir[d]);
    end
    din[d] = data; dec[d] = dc; key[d] = k; iv[d] = 1'b1;
    exp_q.push_back('{dat: exp_dat, err: exp_err});
    @(posedge clk); #1;
    iv[d] = 1'b0; din[d] = ~data; dec[d] = ~dc; key[d] = ~k;
  endtask

  // Count cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (!ov[d] && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake(input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ir[d], ov[d], dout[d], err[d], bsy[d]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_vals dut=%0d rdy/vld/dat/err/busy=%b/%b/%h/%b/%b expected 1/0/00000000/0/0",
                 d, ir[d], ov[d], dout[d], err[d], bsy[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decrypt();
    logic [31:0] ys [3];
    logic [31:0] xs [3];
    exp_t e;
    int lat;
    ys[0] = 32'd324; ys[1] = 32'd24; ys[2] = 32'd27;
    xs[0] = 32'd100; xs[1] = 32'd0;  xs[2] = 32'd5;
    for (int i = 0; i < 3; i++) begin
      drive(0, ys[i], 1'b1, 16'h0032, xs[i], 1'b0);
      checks++;
      if (ir[0] !== 1'b0 || bsy[0] !== 1'b1) begin
        failures++;
        $display("FAIL dec_busy in_ready=%b busy=%b expected 0/1", ir[0], bsy[0]);
      end
      wait_out(0, lat);
      e = exp_q.pop_front();
      checks++;
      if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err) begin
        failures++;
        $display("FAIL dec_result in=%0d vld=%b data=%h err=%b expected 1/%h/%b", ys[i], ov[0], dout[0], err[0], e.dat, e.err);
      end
      checks++;
      if (lat !== 33) begin
        failures++;
        $display("FAIL dec_latency in=%0d latency=%0d expected 33", ys[i], lat);
      end
      handshake(0);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    int lat;
    drive(0, 32'h12345678, 1'b0, 16'h0032, 32'h12345678, 1'b0);
    wait_out(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err || lat !== 1) begin
      failures++;
      $display("FAIL bypass vld=%b data=%h err=%b latency=%0d expected 1/%h/%b/1", ov[0], dout[0], err[0], lat, e.dat, e.err);
    end
    handshake(0);
  endtask

  task automatic test_key_err();
    exp_t e;
    int lat;
    drive(0, 32'd324, 1'b1, 16'h0031, 32'd324, 1'b1);
    wait_out(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err || lat !== 1) begin
      failures++;
      $display("FAIL key_err vld=%b data=%h err=%b latency=%0d expected 1/%h/%b/1", ov[0], dout[0], err[0], lat, e.dat, e.err);
    end
    handshake(0);
    drive(0, 32'd324, 1'b1, 16'h0032, 32'd100, 1'b0);
    wait_out(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err) begin
      failures++;
      $display("FAIL key_recover vld=%b data=%h err=%b expected 1/%h/%b", ov[0], dout[0], err[0], e.dat, e.err);
    end
    handshake(0);
  endtask

  task automatic test_hold();
    exp_t e;
    int lat;
    int bad = 0;
    drive(0, 32'hDEADBEEF, 1'b1, 16'h0000, 32'hDEADBEEF, 1'b1);
    wait_out(0, lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err || ir[0] !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable unstable_cycles=%0d expected 0 (last vld=%b data=%h err=%b rdy=%b)", bad, ov[0], dout[0], err[0], ir[0]);
    end
    handshake(0);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL hold_release vld=%b rdy=%b busy=%b expected 0/1/0", ov[0], ir[0], bsy[0]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    int seen = 0;
    drive(0, 32'd324, 1'b1, 16'h0032, 32'd100, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_mul busy=%b vld=%b expected 1/0", bsy[0], ov[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ir[0], ov[0], dout[0], err[0], bsy[0]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid rdy/vld/dat/err/busy=%b/%b/%h/%b/%b expected 1/0/00000000/0/0",
               ir[0], ov[0], dout[0], err[0], bsy[0]);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ov[0]) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_spurious out_valid_cycles=%0d expected 0", seen);
    end
    drive(0, 32'd324, 1'b1, 16'h0032, 32'd100, 1'b0);
    wait_out(0, lat);
    e = exp_q.pop_front();
    checks++;
    if (ov[0] !== 1'b1 || dout[0] !== e.dat || err[0] !== e.err || lat !== 33) begin
      failures++;
      $display("FAIL after_reset vld=%b data=%h err=%b latency=%0d expected 1/%h/%b/33", ov[0], dout[0], err[0], lat, e.dat, e.err);
    end
    handshake(0);
  endtask

  task automatic test_sweep();
    logic [31:0] edge_v [6];
    logic [31:0] x;
    exp_t e;
    int lat;
    int exp_lat;
    edge_v[0] = 32'h0;        edge_v[1] = 32'h1;        edge_v[2] = 32'h3;
    edge_v[3] = 32'hFFFFFFFF; edge_v[4] = 32'hFFFFFFFD; edge_v[5] = 32'h80000000;
    for (int d = 0; d < 3; d++) begin
      exp_lat = 32 / (1 << d) + 1;
      for (int i = 0; i < 20; i++) begin
        x = (i < 6) ? edge_v[i] : $urandom;
        drive(d, enc(x), 1'b1, 16'h0032, x, 1'b0);
        wait_out(d, lat);
        e = exp_q.pop_front();
        checks++;
        if (ov[d] !== 1'b1 || dout[d] !== e.dat || err[d] !== e.err) begin
          failures++;
          $display("FAIL sweep_data iter_bits=%0d x=%h vld=%b data=%h err=%b expected 1/%h/%b",
                   1 << d, x, ov[d], dout[d], err[d], e.dat, e.err);
        end
        checks++;
        if (lat !== exp_lat) begin
          failures++;
          $display("FAIL sweep_latency iter_bits=%0d latency=%0d expected %0d", 1 << d, lat, exp_lat);
        end
        handshake(d);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; dec[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0; key[d] = '0;
    end
    test_reset();
    test_decrypt();
    test_bypass();
    test_key_err();
    test_hold();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
